// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive vector sequencer and checker for a small
// combinational block. Each N_IN-bit input vector is driven for DWELL cycles
// and the DUT output is compared with EXPECT[vec_out] on the last dwell cycle.
// Optional build macro SWEEP_GRAY_EN: visit vectors in reflected Gray order
// instead of binary ascending order. Latency and EXPECT indexing are unchanged.
//
// Control semantics: start is a level, sampled only on edges where the FSM is
// in IDLE or DONE. It is ignored while busy. A start held high into DONE
// restarts the sweep on the very next edge.
module truth_table_sweeper #(
  parameter int                      N_IN   = 3,
  parameter int                      DWELL  = 50,
  parameter logic [(2**N_IN)-1:0]    EXPECT = 8'hE8,
  parameter int                      CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic             dut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_idx,
  output logic             first_err_vld,
  output logic [1:0]       dbg_state
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [N_IN-1:0]  BIN_LAST   = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] ERR_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  bin_q, bin_d;       // position in the sweep (binary)
  logic [N_IN-1:0]  vec_q, vec_d;       // vector presented to the DUT
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  fidx_q, fidx_d;
  logic             fvld_q, fvld_d;

  logic             sample;
  logic             mismatch;
  logic [N_IN-1:0]  bin_next;

  // Map a sweep position to the vector value driven onto the DUT.
  function automatic logic [N_IN-1:0] to_vec(input logic [N_IN-1:0] b);
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Next-state, counters and result bookkeeping.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    vec_d    = vec_q;
    dwell_d  = dwell_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fvld_d   = fvld_q;
    bin_next = bin_q + N_IN'(1);
    // The compare uses the registered vector, so the sample and the switch
    // to the next vector can share an edge without the DUT losing a cycle.
    sample   = (state_q == RUN) && (dwell_q == DWELL_LAST);
    mismatch = sample && (dut_f != EXPECT[vec_q]);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          bin_d   = '0;
          vec_d   = '0;
          dwell_d = '0;
          err_d   = '0;
          fidx_d  = '0;
          fvld_d  = 1'b0;
        end
      end
      RUN: begin
        if (sample) begin
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + CNT_W'(1);
            if (!fvld_q) begin
              fidx_d = vec_q;
              fvld_d = 1'b1;
            end
          end
          if (bin_q == BIN_LAST) begin
            state_d = DONE;
          end else begin
            bin_d   = bin_next;
            vec_d   = to_vec(bin_next);
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      vec_q   <= '0;
      dwell_q <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
    end
  end

  assign vec_out       = vec_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = (state_q == DONE) && (err_q == '0);
  assign err_cnt       = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: N_IN=3, DWELL=4, majority truth
// table, plus a CNT_W=2 saturation instance and a DWELL=1 instance.
module tb_truth_table_sweeper;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- DUT A: main instance ----------------
  logic       start_a = 1'b0;
  logic [1:0] mode_a  = 2'd0;   // 0 majority, 1 tied 0, 2 inverted majority
  logic [2:0] vec_a;
  logic       dut_f_a, busy_a, done_a, pass_a, fvld_a;
  logic [7:0] err_a;
  logic [2:0] fidx_a;
  logic [1:0] st_a;

  // ---------------- DUT S: CNT_W=2 saturation ----------------
  logic       start_b = 1'b0;
  logic [2:0] vec_s;
  logic       dut_f_s, busy_s, done_s, pass_s, fvld_s;
  logic [1:0] err_s;
  logic [2:0] fidx_s;
  logic [1:0] st_s;

  // ---------------- DUT D: DWELL=1 ----------------
  logic [2:0] vec_d1;
  logic       dut_f_d1, busy_d1, done_d1, pass_d1, fvld_d1;
  logic [7:0] err_d1;
  logic [2:0] fidx_d1;
  logic [1:0] st_d1;

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic [2:0] exp_vec(input int i);
    logic [2:0] b;
    b = 3'(i);
`ifdef SWEEP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  assign dut_f_a  = (mode_a == 2'd0) ? maj(vec_a) :
                    (mode_a == 2'd1) ? 1'b0 : ~maj(vec_a);
  assign dut_f_s  = ~maj(vec_s);
  assign dut_f_d1 = maj(vec_d1);

  truth_table_sweeper #(.N_IN(3), .DWELL(4), .EXPECT(8'hE8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_f(dut_f_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_err_idx(fidx_a), .first_err_vld(fvld_a), .dbg_state(st_a)
  );

  truth_table_sweeper #(.N_IN(3), .DWELL(4), .EXPECT(8'hE8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_s), .dut_f(dut_f_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
    .first_err_idx(fidx_s), .first_err_vld(fvld_s), .dbg_state(st_s)
  );

  truth_table_sweeper #(.N_IN(3), .DWELL(1), .EXPECT(8'hE8), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_d1), .dut_f(dut_f_d1),
    .busy(busy_d1), .done(done_d1), .pass(pass_d1), .err_cnt(err_d1),
    .first_err_idx(fidx_d1), .first_err_vld(fvld_d1), .dbg_state(st_d1)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic check_a_all_zero(input string tag);
    check({tag, "_vec"},   32'(vec_a),  32'd0);
    check({tag, "_busy"},  32'(busy_a), 32'd0);
    check({tag, "_done"},  32'(done_a), 32'd0);
    check({tag, "_pass"},  32'(pass_a), 32'd0);
    check({tag, "_err"},   32'(err_a),  32'd0);
    check({tag, "_fidx"},  32'(fidx_a), 32'd0);
    check({tag, "_fvld"},  32'(fvld_a), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];

  initial begin
    logic [2:0] e;

    // Reset state
    ticks(3);
    check_a_all_zero("reset");
    rst = 1'b0;
    tick();
    check_a_all_zero("idle");

    // 1: majority DUT, full sweep, vector order and dwell
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_vec(i));
    mode_a = 2'd0;
    pulse_start_a();                      // now just after edge k
    check("t1_busy_k", 32'(busy_a), 32'd1);
    for (int n = 0; n < 32; n++) begin
      if (n % 4 == 0) e = exp_q.pop_front();
      check("t1_vec", 32'(vec_a), 32'(e));
      check("t1_done_low", 32'(done_a), 32'd0);
      tick();
    end
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd0);
    check("t1_pass", 32'(pass_a), 32'd1);
    check("t1_err",  32'(err_a),  32'd0);
    check("t1_fvld", 32'(fvld_a), 32'd0);
    check("t1_vec_hold", 32'(vec_a), 32'(exp_vec(7)));
    tick();
    check("t1_done_stays", 32'(done_a), 32'd1);

    // 2: DUT output tied low, restart from DONE
    mode_a = 2'd1;
    pulse_start_a();
    check("t2_done_clr", 32'(done_a), 32'd0);
    check("t2_pass_clr", 32'(pass_a), 32'd0);
    check("t2_vec0",     32'(vec_a),  32'd0);
    ticks(32);
    check("t2_done", 32'(done_a), 32'd1);
    check("t2_err",  32'(err_a),  32'd4);
    check("t2_fidx", 32'(fidx_a), 32'd3);
    check("t2_fvld", 32'(fvld_a), 32'd1);
    check("t2_pass", 32'(pass_a), 32'd0);

    // 3: reset at k+10 abandons sweep, then a clean sweep
    mode_a = 2'd2;
    pulse_start_a();
    ticks(9);                             // just after edge k+9
    check("t3_err_pre",  32'(err_a),  32'd2);
    check("t3_fvld_pre", 32'(fvld_a), 32'd1);
    check("t3_vec_pre",  32'(vec_a),  32'(exp_vec(2)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_a_all_zero("t3_rst");
    mode_a = 2'd0;
    pulse_start_a();
    ticks(31);
    check("t3_done_early", 32'(done_a), 32'd0);
    tick();
    check("t3_done", 32'(done_a), 32'd1);
    check("t3_pass", 32'(pass_a), 32'd1);

    // 4: start held high through RUN and into DONE
    start_a = 1'b1;
    tick();                               // edge k
    ticks(31);
    check("t4_done_k31", 32'(done_a), 32'd0);
    check("t4_busy_k31", 32'(busy_a), 32'd1);
    tick();
    check("t4_done_k32", 32'(done_a), 32'd1);
    check("t4_pass_k32", 32'(pass_a), 32'd1);
    tick();                               // held start restarts here
    check("t4_restart_done", 32'(done_a), 32'd0);
    check("t4_restart_busy", 32'(busy_a), 32'd1);
    check("t4_restart_vec",  32'(vec_a),  32'd0);
    ticks(31);
    check("t4_done_low31", 32'(done_a), 32'd0);
    tick();
    check("t4_done_again", 32'(done_a), 32'd1);
    start_a = 1'b0;
    tick();
    check("t4_no_restart", 32'(done_a), 32'd1);

    // 5: CNT_W=2 saturation, and DWELL=1 running alongside
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check("d1_vec", 32'(vec_d1), 32'(exp_vec(n)));
      check("d1_done_low", 32'(done_d1), 32'd0);
      tick();
    end
    check("d1_done", 32'(done_d1), 32'd1);
    check("d1_pass", 32'(pass_d1), 32'd1);
    check("d1_err",  32'(err_d1),  32'd0);
    check("sat_busy_mid", 32'(busy_s), 32'd1);
    ticks(23);
    check("sat_done_early", 32'(done_s), 32'd0);
    tick();
    check("sat_done", 32'(done_s), 32'd1);
    check("sat_err",  32'(err_s),  32'd3);
    check("sat_fidx", 32'(fidx_s), 32'd0);
    check("sat_fvld", 32'(fvld_s), 32'd1);
    check("sat_pass", 32'(pass_s), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
